// File: rtl/sudoku_board_ctrl.sv
// sudoku_board_ctrl: N x N Sudoku board controller (ROM->RAM load, cursor, protected RMW digit writes).
// Define SUDOKU_ROW_CONFLICT_EN to also refuse digits that already appear elsewhere in the cursor row.
module sudoku_board_ctrl #(
    parameter int N    = 4,
    parameter int DW   = 4,
    parameter int NPUZ = 4,
    parameter int RAW  = $clog2(N),
    parameter int PSW  = $clog2(NPUZ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [PSW-1:0]       puzzleSel,
    input  logic [DW-1:0]        userNum,
    input  logic                 upButton,
    input  logic                 dnButton,
    input  logic                 leftButton,
    input  logic                 rightButton,
    input  logic                 writeBit,
    output logic [N*DW-1:0]      currentRow,
    output logic [N-1:0]         currentNum,
    output logic [RAW-1:0]       currentRowAddr,
    output logic                 noWrite,
    output logic                 busy,
    output logic                 writeDone,
    output logic                 writeReject,
    output logic [PSW+RAW-1:0]   RomAddr,
    input  logic [N+N*DW-1:0]    RomDat,
    output logic [RAW-1:0]       RamAddr,
    output logic [N*DW-1:0]      RamWdat,
    output logic                 RamWriteBit,
    input  logic [N*DW-1:0]      RamDat
);
    typedef enum logic [2:0] {LD_RD, LD_WR, IDLE, WR_RD, WR_WR} state_t;
    localparam logic [RAW-1:0] LAST = RAW'(N - 1);
    state_t         state_q;
    logic [RAW-1:0] row_q, col_q, cur_row_q;
    logic [PSW-1:0] psel_q;
    logic           first_q, done_q, rej_q;
    logic [N-1:0]   prot_q [N];
    logic [5:0]     btn, btn_q, rise;
    logic [N*DW-1:0] merged;
    logic           conflict;
    assign btn  = {start, writeBit, leftButton, rightButton, upButton, dnButton};
    assign rise = btn & ~btn_q;
    assign currentRow     = RamDat;
    assign currentNum     = N'(1) << col_q;
    assign currentRowAddr = cur_row_q;
    assign noWrite        = prot_q[cur_row_q][col_q];
    assign busy           = state_q != IDLE;
    assign writeDone      = done_q;
    assign writeReject    = rej_q;
    // The first LOAD cycle addresses the ROM with the live selector, which is latched at its end.
    assign RomAddr     = {first_q ? puzzleSel : psel_q, row_q};
    assign RamAddr     = state_q == LD_WR ? row_q : cur_row_q;
    assign RamWriteBit = !rise[5] && (state_q == LD_WR || state_q == WR_WR);
    assign RamWdat     = state_q == LD_WR ? RomDat[N*DW-1:0] : state_q == WR_WR ? merged : '0;
    always_comb begin
        merged = RamDat;
        merged[col_q*DW +: DW] = userNum;
    end
`ifdef SUDOKU_ROW_CONFLICT_EN
    always_comb begin
        conflict = 1'b0;
        for (int c = 0; c < N; c++)
            if (RAW'(c) != col_q && userNum != '0 && RamDat[c*DW +: DW] == userNum) conflict = 1'b1;
    end
`else
    assign conflict = 1'b0;
`endif
    // Edge registers reset high so a level already held through reset needs a fresh press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= LD_RD;
            row_q     <= '0;
            col_q     <= '0;
            cur_row_q <= '0;
            psel_q    <= '0;
            first_q   <= 1'b1;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            btn_q     <= '1;
            for (int i = 0; i < N; i++) prot_q[i] <= '0;
        end else begin
            btn_q  <= btn;
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            if (rise[5]) begin
                state_q   <= LD_RD;
                row_q     <= '0;
                col_q     <= '0;
                cur_row_q <= '0;
                first_q   <= 1'b1;
            end else begin
                case (state_q)
                    LD_RD: begin
                        if (first_q) psel_q <= puzzleSel;
                        first_q <= 1'b0;
                        state_q <= LD_WR;
                    end
                    LD_WR: begin
                        prot_q[row_q] <= RomDat[N*DW +: N];
                        row_q   <= row_q == LAST ? '0 : row_q + 1'b1;
                        state_q <= row_q == LAST ? IDLE : LD_RD;
                    end
                    IDLE: begin
                        if (rise[4]) begin
                            if (noWrite) rej_q <= 1'b1;
                            else state_q <= WR_RD;
                        end else if (rise[3]) col_q <= col_q == LAST ? '0 : col_q + 1'b1;
                        else if (rise[2]) col_q <= col_q == '0 ? LAST : col_q - 1'b1;
                        else if (rise[1]) cur_row_q <= cur_row_q == '0 ? LAST : cur_row_q - 1'b1;
                        else if (rise[0]) cur_row_q <= cur_row_q == LAST ? '0 : cur_row_q + 1'b1;
                    end
                    WR_RD: begin
                        rej_q   <= conflict;
                        state_q <= conflict ? IDLE : WR_WR;
                    end
                    WR_WR: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
